// File: rtl/timer_set_ctrl.sv
// -----------------------------------------------------------------------------
// timer_set_ctrl
//   Button-driven preset editor for the countdown timer. Holds the preset as
//   packed BCD hours/minutes/seconds and edits one field at a time from
//   single-cycle debounced button pulses. While any field is being set,
//   `stop` is high so the downstream timer keeps reloading the preset.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_mode   pulse: enter / leave set mode
//   btn_sel    pulse: advance selected field (hour -> min -> sec -> hour)
//   btn_up     pulse: increment selected field (wraps max -> 00)
//   btn_down   pulse: decrement selected field (wraps 00 -> max)
//   timer_hour BCD hours {tens, ones}
//   timer_min  BCD minutes
//   timer_sec  BCD seconds
//   stop       high in every set state, low in RUN
//   set_field  0 = none (RUN), 1 = hour, 2 = min, 3 = sec
//   blink      1 = selected field visible, 0 = blanked
// -----------------------------------------------------------------------------
module timer_set_ctrl #(
    parameter int HOUR_MAX  = 23,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] timer_hour,
    output logic [7:0] timer_min,
    output logic [7:0] timer_sec,
    output logic       stop,
    output logic [1:0] set_field,
    output logic       blink
);

    localparam int              CNT_W        = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BLINK_DIV - 1);
    localparam logic [7:0]      HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

    // State encoding equals the set_field code, so set_field is the state register.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        S_HOUR = 2'd1,
        S_MIN  = 2'd2,
        S_SEC  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_UP    = 2'd1,
        OP_DOWN  = 2'd2,
        OP_CLEAR = 2'd3
    } edit_op_t;

    state_t           state_reg, state_next;
    logic             stop_reg, stop_next;
    logic             blink_reg, blink_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    edit_op_t         edit_op;

    // Wrap check is on the whole field; otherwise step the ones digit with carry.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        if (val == max)
            return 8'h00;
        else if (val[3:0] == 4'd9)
            return {val[7:4] + 4'd1, 4'd0};
        else
            return {val[7:4], val[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] max);
        if (val == 8'h00)
            return max;
        else if (val[3:0] == 4'd0)
            return {val[7:4] - 4'd1, 4'd9};
        else
            return {val[7:4], val[3:0] - 4'd1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            stop_reg  <= 1'b0;
            blink_reg <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            stop_reg  <= stop_next;
            blink_reg <= blink_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Buttons are resolved with mode > sel > up/down; losers are dropped.
    always_comb begin
        state_next = state_reg;
        blink_next = blink_reg;
        cnt_next   = cnt_reg;
        edit_op    = OP_NONE;

        if (btn_mode) begin
            state_next = (state_reg == RUN) ? S_HOUR : RUN;
            blink_next = 1'b1;
            cnt_next   = '0;
        end else if (state_reg == RUN) begin
            blink_next = 1'b1;
            cnt_next   = '0;
        end else if (btn_sel) begin
            unique case (state_reg)
                S_HOUR:  state_next = S_MIN;
                S_MIN:   state_next = S_SEC;
                default: state_next = S_HOUR;
            endcase
            blink_next = 1'b1;
            cnt_next   = '0;
        end else if (btn_up || btn_down) begin
            edit_op    = edit_op_t'({btn_down, btn_up});
            blink_next = 1'b1;
            cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
            blink_next = ~blink_reg;
            cnt_next   = '0;
        end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
        end

        // Registered from the next state so stop moves in lockstep with set_field.
        stop_next = (state_next != RUN);
    end

    // One register per BCD field; only the field owned by the current state edits.
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
        localparam logic [7:0] FIELD_MAX = (gi == 0) ? HOUR_MAX_BCD : 8'h59;
        localparam logic [1:0] OWN_STATE = 2'(gi + 1);

        logic [7:0] value_reg, value_next;

        always_comb begin
            value_next = value_reg;
            if (state_reg == OWN_STATE) begin
                unique case (edit_op)
                    OP_UP:    value_next = bcd_inc(value_reg, FIELD_MAX);
                    OP_DOWN:  value_next = bcd_dec(value_reg, FIELD_MAX);
                    OP_CLEAR: value_next = 8'h00;
                    default:  value_next = value_reg;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst)
                value_reg <= 8'h00;
            else
                value_reg <= value_next;
        end
    end

    assign timer_hour = g_field[0].value_reg;
    assign timer_min  = g_field[1].value_reg;
    assign timer_sec  = g_field[2].value_reg;
    assign stop       = stop_reg;
    assign set_field  = state_reg;
    assign blink      = blink_reg;

endmodule
